uart_tx_queue: RTL and testbench
================================

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter DEPTH_LOG2, default 9, meaning queue depth = 2^DEPTH_LOG2 bytes (512).
REQ-002 ICE_CLK  input  1  single system clock; all logic on its rising edge.
REQ-003 ICE_RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 in_dv  input  1  receive-data-valid from the UART receiver; a level, rising edge = one new byte.
REQ-005 in_byte  input  8  received byte; stable while in_dv high.
REQ-006 tx_done  input  1  transmitter idle level; high = idle, low = shifting a byte.
REQ-007 tx_dv  output  1  one-cycle start strobe to the transmitter.
REQ-008 tx_byte  output  8  byte to transmit; registered.
REQ-009 count  output  DEPTH_LOG2+1  bytes currently queued.
REQ-010 empty / full  output  1 each  count==0 / count==2^DEPTH_LOG2.
REQ-011 overflow  output  1  sticky; set when a byte is dropped because the queue is full.

Function
REQ-012 Block shall register in_dv and detect its rising edge (in_dv=1, previous=0); exactly one write per rising edge regardless of how long in_dv stays high.
REQ-013 On a detected edge with full=0, in_byte shall be written at the write pointer on that clock edge and the write pointer incremented modulo 2^DEPTH_LOG2.
REQ-014 On a detected edge with full=1, the byte shall be discarded, pointers and count unchanged, overflow set to 1.
REQ-015 Storage shall be synchronous-read RAM with one-cycle read latency (inferable as iCE40 block RAM).
REQ-016 Pointers shall be DEPTH_LOG2 bits, wrapping 2^DEPTH_LOG2-1 -> 0 with no data loss or pointer reset at wrap.
REQ-017 count shall be +1 on write only, -1 on read-pop only, unchanged on simultaneous write and pop.
REQ-018 Output FSM states: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE: if empty=0 and tx_done=1 -> LOAD; read issued at read pointer, read pointer incremented, count decremented (pop) on this transition.
REQ-020 LOAD: capture RAM output into tx_byte -> START.
REQ-021 START: tx_dv=1 for exactly this one cycle -> WAIT_BUSY.
REQ-022 WAIT_BUSY: stay until tx_done=0, then -> WAIT_DONE.
REQ-023 WAIT_DONE: stay until tx_done=1, then -> IDLE.
REQ-024 tx_dv shall be 0 in every state other than START.
REQ-025 tx_byte shall hold its value from LOAD exit until the next LOAD exit.
REQ-026 Latency: with queue empty, FSM in IDLE, tx_done=1, tx_dv shall assert exactly 3 ICE_CLK edges after the edge at which the in_dv rising edge is first sampled.
REQ-027 A write arriving in the same cycle as a pop shall not corrupt the byte being read (distinct addresses guaranteed unless count==0, in which case no pop occurs).
REQ-028 Back-to-back bytes shall be transmitted in arrival order with no byte duplicated or skipped.

Reset
REQ-029 ICE_RST_N=0 shall immediately force: pointers=0, count=0, empty=1, full=0, overflow=0, tx_dv=0, tx_byte=8'h00, FSM=IDLE, in_dv edge register=0.
REQ-030 Reset mid-transmission shall drop all queued bytes; RAM contents need not be cleared.
REQ-031 After ICE_RST_N deasserts, an in_dv already high shall not be counted as a rising edge until it returns low and rises again... except when in_dv is low at release, in which case the next rise counts normally.

Verification
REQ-032 Single byte: reset, tx_done=1, pulse in_dv 1 cycle with in_byte=8'h41 -> tx_dv high exactly 3 edges later, tx_byte=8'h41, count 1 then 0.
REQ-033 Stretched strobe: in_dv high 20 cycles, in_byte=8'h55 -> exactly one write, count=1, one tx_dv.
REQ-034 Ordering with slow transmitter: write 8'h01,8'h02,8'h03; model tx_done low 100 cycles after each tx_dv -> tx_dv three times, tx_byte 01,02,03 in order, no tx_dv while tx_done low.
REQ-035 Full/overflow: tx_done held 0, write 513 bytes (DEPTH_LOG2=9) -> full=1 after 512th, 513th dropped, overflow=1, count=512; release tx_done -> first 512 bytes emitted in order.
REQ-036 Wrap: stream 1000 bytes value i mod 256 with idle transmitter -> all 1000 emitted in order, pointers wrap cleanly, count returns to 0.
REQ-037 Async reset: assert ICE_RST_N=0 mid-WAIT_DONE with count=5 -> same-cycle count=0, empty=1, tx_dv=0, overflow=0; no further tx_dv after release.

Source files
------------

// File: rtl/uart_tx_queue.sv
// uart_tx_queue
// Byte queue between a UART receiver and a UART transmitter. Each rising
// edge of in_dv pushes in_byte into a block-RAM backed FIFO. A small FSM pops
// bytes one at a time and hands them to the transmitter with a one-cycle
// tx_dv strobe. It waits for the transmitter to go busy and then idle again
// before it sends the next byte.
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  ICE_CLK,
    input  logic                  ICE_RST_N,
    input  logic                  in_dv,
    input  logic [7:0]            in_byte,
    input  logic                  tx_done,
    output logic                  tx_dv,
    output logic [7:0]            tx_byte,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);

    localparam logic [DEPTH_LOG2:0]   DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    // Storage
    logic [7:0]            mem [0:(1 << DEPTH_LOG2) - 1];
    logic [7:0]            rd_data_r;

    // Input edge detection
    logic                  in_dv_r;
    logic                  armed_r;
    logic                  rise_s;
    logic                  wr_en_s;
    logic                  drop_s;

    // Queue bookkeeping
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic [DEPTH_LOG2:0]   count_next_s;
    logic                  empty_r;
    logic                  full_r;
    logic                  overflow_r;

    // Output FSM
    state_t                state_r;
    state_t                state_next_s;
    logic                  pop_s;
    logic                  load_s;
    logic                  tx_dv_r;
    logic [7:0]            tx_byte_r;

    // A high level is only a new byte if in_dv was seen low since reset
    // release, so a strobe already high at release is ignored.
    assign rise_s = in_dv & ~in_dv_r & armed_r;

    // Track the previous in_dv level and whether a low level has been seen
    always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
        if (!ICE_RST_N) begin
            in_dv_r <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            in_dv_r <= in_dv;
            armed_r <= armed_r | ~in_dv;
        end
    end

    // Accept or drop a newly arrived byte depending on queue room
    always_comb begin
        wr_en_s = 1'b0;
        drop_s  = 1'b0;
        if (rise_s) begin
            if (full_r) begin
                drop_s = 1'b1;
            end else begin
                wr_en_s = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
            drop_s  = 1'b0;
        end
    end

    // Next occupancy: a write and a pop in the same cycle cancel out
    always_comb begin
        count_next_s = count_r;
        case ({wr_en_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Queue storage has one write port and a registered read port, with no reset so it maps to block RAM
    always_ff @(posedge ICE_CLK) begin
        if (wr_en_s) begin
            mem[wr_ptr_r] <= in_byte;
        end
        if (pop_s) begin
            rd_data_r <= mem[rd_ptr_r];
        end
    end

    // Pointers, occupancy, status flags and sticky overflow
    always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
        if (!ICE_RST_N) begin
            wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
            count_r    <= {(DEPTH_LOG2 + 1){1'b0}};
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            count_r <= count_next_s;
            empty_r <= (count_next_s == {(DEPTH_LOG2 + 1){1'b0}});
            full_r  <= (count_next_s == DEPTH_C);
        end
    end

    // Next state for the transmit handshake, plus the pop and load strobes
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_r && tx_done) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_s       = 1'b1;
                state_next_s = ST_START;
            end
            ST_START: begin
                state_next_s = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!tx_done) begin
                    state_next_s = ST_WAIT_DONE;
                end else begin
                    state_next_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
        if (!ICE_RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // tx_dv is high only while in START, and tx_byte is captured when LOAD is left
    always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
        if (!ICE_RST_N) begin
            tx_dv_r   <= 1'b0;
            tx_byte_r <= 8'h00;
        end else begin
            tx_dv_r <= (state_next_s == ST_START);
            if (load_s) begin
                tx_byte_r <= rd_data_r;
            end
        end
    end

    assign tx_dv    = tx_dv_r;
    assign tx_byte  = tx_byte_r;
    assign count    = count_r;
    assign empty    = empty_r;
    assign full     = full_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue. It uses a behavioural transmitter that
// drops tx_done for a programmable time after each tx_dv strobe and logs every
// byte it is handed.
`timescale 1ns/1ps
module tb_uart_tx_queue;

    logic        ICE_CLK = 1'b0;
    logic        ICE_RST_N;
    logic        in_dv;
    logic [7:0]  in_byte;
    logic        tx_done = 1'b1;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic [9:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;

    int          n_checks = 0;
    int          n_pass   = 0;

    // transmitter model state
    logic        tx_force_low;
    int          busy_len;
    int          busy_cnt = 0;
    int          rx_n     = 0;
    int          viol     = 0;
    logic [7:0]  rx_mem [0:4095];

    uart_tx_queue #(.DEPTH_LOG2(9)) dut (
        .ICE_CLK   (ICE_CLK),
        .ICE_RST_N (ICE_RST_N),
        .in_dv     (in_dv),
        .in_byte   (in_byte),
        .tx_done   (tx_done),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow)
    );

    always #5 ICE_CLK = ~ICE_CLK;

    // Transmitter model: log strobed bytes, then go busy for busy_len+1 cycles
    always @(negedge ICE_CLK) begin
        if (tx_dv) begin
            if (rx_n < 4096) rx_mem[rx_n] <= tx_byte;
            rx_n <= rx_n + 1;
            if (!tx_done) viol <= viol + 1;
        end
        if (tx_force_low) begin
            tx_done  <= 1'b0;
            busy_cnt <= 0;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            tx_done  <= 1'b0;
        end else if (tx_dv) begin
            tx_done  <= 1'b0;
            busy_cnt <= busy_len;
        end else begin
            tx_done  <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge ICE_CLK);
        #1;
    endtask

    task automatic pulse_byte(input logic [7:0] b, input int gap);
        in_byte = b;
        in_dv   = 1'b1;
        tick();
        in_dv   = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_rx(input string tag, input int target, input int budget);
        int k = 0;
        while (rx_n < target && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(rx_n), 32'(target));
    endtask

    initial begin
        int base;
        int errs;
        ICE_RST_N    = 1'b0;
        in_dv        = 1'b0;
        in_byte      = 8'h00;
        tx_force_low = 1'b0;
        busy_len     = 1;
        repeat (2) tick();

        // reset state
        check_eq("rst_count",    32'(count),    32'd0);
        check_eq("rst_empty",    32'(empty),    32'd1);
        check_eq("rst_full",     32'(full),     32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_tx_dv",    32'(tx_dv),    32'd0);
        check_eq("rst_tx_byte",  32'(tx_byte),  32'h00);
        ICE_RST_N = 1'b1;
        repeat (3) tick();

        // single byte: written at E0, popped at E1, strobe high from E2 across E3
        base    = rx_n;
        in_byte = 8'h41;
        in_dv   = 1'b1;
        tick();
        check_eq("t1_count_after_write", 32'(count), 32'd1);
        in_dv = 1'b0;
        tick();
        check_eq("t1_count_after_pop", 32'(count), 32'd0);
        check_eq("t1_tx_dv_e1", 32'(tx_dv), 32'd0);
        tick();
        check_eq("t1_tx_dv_e2", 32'(tx_dv), 32'd1);
        check_eq("t1_tx_byte", 32'(tx_byte), 32'h41);
        tick();
        check_eq("t1_tx_dv_e3", 32'(tx_dv), 32'd0);
        wait_rx("t1_rx_n", base + 1, 50);
        check_eq("t1_rx_byte", 32'(rx_mem[base]), 32'h41);
        repeat (10) tick();

        // stretched strobe: one write only
        base    = rx_n;
        in_byte = 8'h55;
        in_dv   = 1'b1;
        tick();
        check_eq("t2_count", 32'(count), 32'd1);
        repeat (19) tick();
        in_dv = 1'b0;
        repeat (30) tick();
        check_eq("t2_rx_n", 32'(rx_n), 32'(base + 1));
        check_eq("t2_rx_byte", 32'(rx_mem[base]), 32'h55);
        check_eq("t2_empty", 32'(empty), 32'd1);

        // ordering with a slow transmitter
        busy_len = 100;
        base     = rx_n;
        pulse_byte(8'h01, 1);
        pulse_byte(8'h02, 1);
        pulse_byte(8'h03, 1);
        wait_rx("t3_rx_n", base + 3, 1000);
        check_eq("t3_b0", 32'(rx_mem[base]),     32'h01);
        check_eq("t3_b1", 32'(rx_mem[base + 1]), 32'h02);
        check_eq("t3_b2", 32'(rx_mem[base + 2]), 32'h03);
        check_eq("t3_no_dv_while_busy", 32'(viol), 32'd0);
        busy_len = 1;
        repeat (150) tick();
        check_eq("t3_rx_extra", 32'(rx_n), 32'(base + 3));

        // wrap: 1000 bytes through a 512 deep queue
        base = rx_n;
        for (int i = 0; i < 1000; i++) pulse_byte(8'(i), 7);
        wait_rx("wrap_rx_n", base + 1000, 200);
        errs = 0;
        for (int i = 0; i < 1000; i++)
            if (rx_mem[base + i] !== 8'(i)) errs++;
        check_eq("wrap_order_errs", 32'(errs), 32'd0);
        check_eq("wrap_count", 32'(count), 32'd0);
        check_eq("wrap_overflow", 32'(overflow), 32'd0);

        // full / overflow with the transmitter held busy
        tx_force_low = 1'b1;
        repeat (3) tick();
        base = rx_n;
        for (int i = 0; i < 513; i++) begin
            pulse_byte(8'(i), 1);
            if (i == 510) begin
                check_eq("full_511_flag",  32'(full),  32'd0);
                check_eq("full_511_count", 32'(count), 32'd511);
            end
            if (i == 511) begin
                check_eq("full_512_flag",  32'(full),     32'd1);
                check_eq("full_512_count", 32'(count),    32'd512);
                check_eq("full_512_ovf",   32'(overflow), 32'd0);
            end
        end
        check_eq("full_513_ovf",   32'(overflow), 32'd1);
        check_eq("full_513_count", 32'(count),    32'd512);
        check_eq("full_no_tx",     32'(rx_n),     32'(base));
        tx_force_low = 1'b0;
        wait_rx("full_rx_n", base + 512, 8000);
        errs = 0;
        for (int i = 0; i < 512; i++)
            if (rx_mem[base + i] !== 8'(i)) errs++;
        check_eq("full_order_errs", 32'(errs), 32'd0);
        repeat (20) tick();
        check_eq("full_drain_count", 32'(count), 32'd0);
        check_eq("full_drain_empty", 32'(empty), 32'd1);
        check_eq("full_ovf_sticky",  32'(overflow), 32'd1);

        // async reset during WAIT_DONE with five bytes queued
        busy_len = 100;
        for (int i = 0; i < 6; i++) pulse_byte(8'(8'hA0 + i), 1);
        repeat (3) tick();
        check_eq("rst_mid_count_before", 32'(count), 32'd5);
        #4;
        ICE_RST_N = 1'b0;
        in_byte   = 8'h99;
        in_dv     = 1'b1;
        #1;
        check_eq("rst_mid_count",    32'(count),    32'd0);
        check_eq("rst_mid_empty",    32'(empty),    32'd1);
        check_eq("rst_mid_tx_dv",    32'(tx_dv),    32'd0);
        check_eq("rst_mid_overflow", 32'(overflow), 32'd0);
        repeat (3) tick();
        ICE_RST_N = 1'b1;
        base = rx_n;
        repeat (300) tick();
        check_eq("rst_no_tx_after", 32'(rx_n),  32'(base));
        check_eq("rst_held_dv_ign", 32'(count), 32'd0);
        in_dv = 1'b0;
        tick();
        pulse_byte(8'h77, 1);
        wait_rx("rst_rearm_rx_n", base + 1, 50);
        check_eq("rst_rearm_byte", 32'(rx_mem[base]), 32'h77);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
